// File: rtl/rv_0_sys_ahb_arbiter.sv
// Two-master AHB-Lite round-robin arbiter with a one-transfer hold register per master.
// Define AHB_ARB_LOCK_EN to honour HLOCK; otherwise the arbiter is pure round-robin.
module rv_0_sys_ahb_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RR_INIT = 0
) (
    input  logic              cpu_clk,
    input  logic              pad_cpu_rst_b,
    input  logic [1:0]        m0_htrans,
    input  logic [ADDR_W-1:0] m0_haddr,
    input  logic              m0_hwrite,
    input  logic [2:0]        m0_hsize,
    input  logic [2:0]        m0_hburst,
    input  logic [3:0]        m0_hprot,
    input  logic              m0_hlock,
    input  logic [DATA_W-1:0] m0_hwdata,
    output logic              m0_hready,
    output logic [DATA_W-1:0] m0_hrdata,
    output logic              m0_hresp,
    input  logic [1:0]        m1_htrans,
    input  logic [ADDR_W-1:0] m1_haddr,
    input  logic              m1_hwrite,
    input  logic [2:0]        m1_hsize,
    input  logic [2:0]        m1_hburst,
    input  logic [3:0]        m1_hprot,
    input  logic              m1_hlock,
    input  logic [DATA_W-1:0] m1_hwdata,
    output logic              m1_hready,
    output logic [DATA_W-1:0] m1_hrdata,
    output logic              m1_hresp,
    output logic [1:0]        biu_pad_htrans,
    output logic [ADDR_W-1:0] biu_pad_haddr,
    output logic              biu_pad_hwrite,
    output logic [2:0]        biu_pad_hsize,
    output logic [2:0]        biu_pad_hburst,
    output logic [3:0]        biu_pad_hprot,
    output logic              biu_pad_hlock,
    output logic [DATA_W-1:0] biu_pad_hwdata,
    input  logic [DATA_W-1:0] pad_biu_hrdata,
    input  logic              pad_biu_hready,
    input  logic [1:0]        pad_biu_hresp
);
    localparam logic RR_M = (RR_INIT != 0);

    logic [1:0]             req, own, rdy, cap;
    logic [1:0]             pend, pend_nxt, busy, busy_nxt;
    logic [1:0][ADDR_W-1:0] in_addr, hold_addr;
    logic [1:0]             in_write, hold_write;
    logic [1:0][2:0]        in_size, hold_size;
    logic [1:0][3:0]        in_prot, hold_prot;
    logic                   gnt, gnt_nxt, last, last_nxt;
    logic                   dvalid, dvalid_nxt, downer, accept;
    logic                   force_gnt, force_m;
    logic                   unused_in;

    assign req      = {m1_htrans[1], m0_htrans[1]};
    assign in_addr  = {m1_haddr, m0_haddr};
    assign in_write = {m1_hwrite, m0_hwrite};
    assign in_size  = {m1_hsize, m0_hsize};
    assign in_prot  = {m1_hprot, m0_hprot};
    assign unused_in = ^{m0_htrans[0], m1_htrans[0], m0_hburst, m1_hburst, pad_biu_hresp[1]};

    // A master is stalled from capture until its own data phase completes.
    assign own    = {dvalid & downer, dvalid & ~downer};
    assign rdy    = ~busy | (own & {2{pad_biu_hready}});
    assign cap    = rdy & req;
    assign accept = pad_biu_hready & pend[gnt];

    always_comb begin
        pend_nxt = pend;
        busy_nxt = busy;
        if (accept)
            pend_nxt[gnt] = 1'b0;
        if (pad_biu_hready && dvalid)
            busy_nxt[downer] = 1'b0;
        pend_nxt   = pend_nxt | cap;
        busy_nxt   = busy_nxt | cap;
        last_nxt   = accept ? gnt : last;
        dvalid_nxt = dvalid;
        if (accept)
            dvalid_nxt = 1'b1;
        else if (pad_biu_hready)
            dvalid_nxt = 1'b0;
    end

    // Grant only moves when the slave can take a new address, keeping the bus stable under waits.
    always_comb begin
        gnt_nxt = gnt;
        if (pad_biu_hready) begin
            if (force_gnt)
                gnt_nxt = force_m;
            else if (pend_nxt == 2'b11)
                gnt_nxt = ~last_nxt;
            else if (pend_nxt[0])
                gnt_nxt = 1'b0;
            else if (pend_nxt[1])
                gnt_nxt = 1'b1;
        end
    end

    always_ff @(posedge cpu_clk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            pend   <= '0;
            busy   <= '0;
            gnt    <= RR_M;
            last   <= ~RR_M;
            dvalid <= 1'b0;
            downer <= 1'b0;
        end else begin
            pend   <= pend_nxt;
            busy   <= busy_nxt;
            gnt    <= gnt_nxt;
            last   <= last_nxt;
            dvalid <= dvalid_nxt;
            if (accept)
                downer <= gnt;
        end
    end

    always_ff @(posedge cpu_clk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            hold_addr  <= '0;
            hold_write <= '0;
            hold_size  <= '0;
            hold_prot  <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (cap[i]) begin
                    hold_addr[i]  <= in_addr[i];
                    hold_write[i] <= in_write[i];
                    hold_size[i]  <= in_size[i];
                    hold_prot[i]  <= in_prot[i];
                end
            end
        end
    end

`ifdef AHB_ARB_LOCK_EN
    logic [1:0] hold_lock;
    logic       lock, lock_nxt, lockm, lockm_nxt;

    always_comb begin
        lock_nxt  = lock;
        lockm_nxt = lockm;
        if (accept) begin
            if (hold_lock[gnt]) begin
                lock_nxt  = 1'b1;
                lockm_nxt = gnt;
            end else if (gnt == lockm) begin
                lock_nxt  = 1'b0;
            end
        end
    end

    always_ff @(posedge cpu_clk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            hold_lock <= '0;
            lock      <= 1'b0;
            lockm     <= 1'b0;
        end else begin
            lock  <= lock_nxt;
            lockm <= lockm_nxt;
            if (cap[0])
                hold_lock[0] <= m0_hlock;
            if (cap[1])
                hold_lock[1] <= m1_hlock;
        end
    end

    assign force_gnt     = lock_nxt;
    assign force_m       = lockm_nxt;
    assign biu_pad_hlock = hold_lock[gnt] & pend[gnt];
`else
    logic unused_lock;
    assign unused_lock   = ^{m0_hlock, m1_hlock};
    assign force_gnt     = 1'b0;
    assign force_m       = 1'b0;
    assign biu_pad_hlock = 1'b0;
`endif

    // Slave port: address stage from the granted hold register, data stage from the owner.
    assign biu_pad_htrans = pend[gnt] ? 2'b10 : 2'b00;
    assign biu_pad_haddr  = hold_addr[gnt];
    assign biu_pad_hwrite = hold_write[gnt];
    assign biu_pad_hsize  = hold_size[gnt];
    assign biu_pad_hprot  = hold_prot[gnt];
    assign biu_pad_hburst = 3'b000;
    assign biu_pad_hwdata = downer ? m1_hwdata : m0_hwdata;

    assign m0_hready = rdy[0];
    assign m1_hready = rdy[1];
    assign m0_hrdata = pad_biu_hrdata;
    assign m1_hrdata = pad_biu_hrdata;
    assign m0_hresp  = own[0] & pad_biu_hresp[0];
    assign m1_hresp  = own[1] & pad_biu_hresp[0];
endmodule

// File: tb/tb_rv_0_sys_ahb_arbiter.sv
// Bench for rv_0_sys_ahb_arbiter: transaction-level model checked every cycle plus directed scenarios.
module tb_rv_0_sys_ahb_arbiter;
    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic [1:0]  m0_htrans, m1_htrans;
    logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata;
    logic        m0_hwrite, m1_hwrite, m0_hlock, m1_hlock;
    logic [2:0]  m0_hsize, m1_hsize, m0_hburst, m1_hburst;
    logic [3:0]  m0_hprot, m1_hprot;
    logic        m0_hready, m1_hready, m0_hresp, m1_hresp;
    logic [31:0] m0_hrdata, m1_hrdata;
    logic [1:0]  biu_htrans;
    logic [31:0] biu_haddr, biu_hwdata;
    logic        biu_hwrite, biu_hlock;
    logic [2:0]  biu_hsize, biu_hburst;
    logic [3:0]  biu_hprot;
    logic [31:0] pad_hrdata;
    logic        pad_hready;
    logic [1:0]  pad_hresp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv_0_sys_ahb_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_INIT(0)) dut (
        .cpu_clk(clk), .pad_cpu_rst_b(rst_b),
        .m0_htrans(m0_htrans), .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize),
        .m0_hburst(m0_hburst), .m0_hprot(m0_hprot), .m0_hlock(m0_hlock), .m0_hwdata(m0_hwdata),
        .m0_hready(m0_hready), .m0_hrdata(m0_hrdata), .m0_hresp(m0_hresp),
        .m1_htrans(m1_htrans), .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize),
        .m1_hburst(m1_hburst), .m1_hprot(m1_hprot), .m1_hlock(m1_hlock), .m1_hwdata(m1_hwdata),
        .m1_hready(m1_hready), .m1_hrdata(m1_hrdata), .m1_hresp(m1_hresp),
        .biu_pad_htrans(biu_htrans), .biu_pad_haddr(biu_haddr), .biu_pad_hwrite(biu_hwrite),
        .biu_pad_hsize(biu_hsize), .biu_pad_hburst(biu_hburst), .biu_pad_hprot(biu_hprot),
        .biu_pad_hlock(biu_hlock), .biu_pad_hwdata(biu_hwdata),
        .pad_biu_hrdata(pad_hrdata), .pad_biu_hready(pad_hready), .pad_biu_hresp(pad_hresp)
    );

    task automatic chk1(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %b want %b", name, got, want);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_masters();
        m0_htrans = 2'b00;
        m1_htrans = 2'b00;
        m0_hlock  = 1'b0;
        m1_hlock  = 1'b0;
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        idle_masters();
        tick();
        tick();
        rst_b = 1'b1;
    endtask

    // Transaction-level model: pending requests per master, outstanding flags, one data-phase slot.
    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [3:0]  prot;
        logic        lk;
    } txn_t;

    txn_t pq0[$];
    txn_t pq1[$];
    bit   mb0, mb1, dv, dow;

    always @(negedge clk) begin : monitor
        logic er0, er1, ns, hit, g;
        txn_t f;
        if (!rst_b) begin
            pq0.delete();
            pq1.delete();
            mb0 = 1'b0;
            mb1 = 1'b0;
            dv  = 1'b0;
            dow = 1'b0;
        end else begin
            er0 = !mb0 || (dv && !dow && pad_hready);
            er1 = !mb1 || (dv && dow && pad_hready);
            chk1("m0_hready", m0_hready, er0);
            chk1("m1_hready", m1_hready, er1);
            chk1("m0_hresp", m0_hresp, dv && !dow && pad_hresp[0]);
            chk1("m1_hresp", m1_hresp, dv && dow && pad_hresp[0]);
            chk32("m0_hrdata", m0_hrdata, pad_hrdata);
            chk32("m1_hrdata", m1_hrdata, pad_hrdata);
            chk32("hburst", 32'(biu_hburst), 32'd0);
            if (dv)
                chk32("hwdata", biu_hwdata, dow ? m1_hwdata : m0_hwdata);
            ns  = (biu_htrans == 2'b10);
            hit = 1'b0;
            g   = 1'b0;
            f   = '0;
            if (!ns) begin
                chk32("htrans_idle", 32'(biu_htrans), 32'd0);
                chk1("hlock_idle", biu_hlock, 1'b0);
            end else begin
                if (pq0.size() > 0 && pq0[0].addr == biu_haddr) begin
                    hit = 1'b1; g = 1'b0; f = pq0[0];
                end else if (pq1.size() > 0 && pq1[0].addr == biu_haddr) begin
                    hit = 1'b1; g = 1'b1; f = pq1[0];
                end
                chk1("bus_xfer_known", hit, 1'b1);
                if (hit) begin
                    chk1("hwrite", biu_hwrite, f.wr);
                    chk32("hsize", 32'(biu_hsize), 32'(f.size));
                    chk32("hprot", 32'(biu_hprot), 32'(f.prot));
`ifdef AHB_ARB_LOCK_EN
                    chk1("hlock", biu_hlock, f.lk);
`else
                    chk1("hlock", biu_hlock, 1'b0);
`endif
                end
            end
            if (dv && pad_hready) begin
                if (dow) mb1 = 1'b0; else mb0 = 1'b0;
                dv = 1'b0;
            end
            if (ns && hit && pad_hready) begin
                if (g) void'(pq1.pop_front()); else void'(pq0.pop_front());
                dv  = 1'b1;
                dow = g;
            end
            if (er0 && m0_htrans[1]) begin
                f.addr = m0_haddr; f.wr = m0_hwrite; f.size = m0_hsize; f.prot = m0_hprot; f.lk = m0_hlock;
                pq0.push_back(f);
                mb0 = 1'b1;
            end
            if (er1 && m1_htrans[1]) begin
                f.addr = m1_haddr; f.wr = m1_hwrite; f.size = m1_hsize; f.prot = m1_hprot; f.lk = m1_hlock;
                pq1.push_back(f);
                mb1 = 1'b1;
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_masters();
        m0_haddr = '0; m1_haddr = '0; m0_hwdata = '0; m1_hwdata = '0;
        m0_hwrite = 1'b0; m1_hwrite = 1'b0;
        m0_hsize = 3'd2; m0_hprot = 4'h3; m0_hburst = 3'b011;
        m1_hsize = 3'd1; m1_hprot = 4'hB; m1_hburst = 3'b001;
        pad_hrdata = '0; pad_hready = 1'b1; pad_hresp = 2'b00;
        #2;
        chk32("rst_htrans", 32'(biu_htrans), 32'd0);
        chk32("rst_haddr", biu_haddr, 32'd0);
        chk1("rst_hlock", biu_hlock, 1'b0);
        chk1("rst_m0_hready", m0_hready, 1'b1);
        chk1("rst_m1_hready", m1_hready, 1'b1);
        chk1("rst_m0_hresp", m0_hresp, 1'b0);
        chk1("rst_m1_hresp", m1_hresp, 1'b0);
        #10 rst_b = 1'b1;
        tick();
        tick();

        // Single m0 read, zero-wait slave
        m0_htrans = 2'b10; m0_haddr = 32'h2000_0010; m0_hwrite = 1'b0; settle();
        chk1("t1_m0_rdy_addr", m0_hready, 1'b1);
        tick(); m0_htrans = 2'b00; settle();
        chk32("t1_bus_ns", 32'(biu_htrans), 32'd2);
        chk32("t1_bus_addr", biu_haddr, 32'h2000_0010);
        chk1("t1_m0_stall", m0_hready, 1'b0);
        tick(); pad_hrdata = 32'hDEAD_BEEF; settle();
        chk1("t1_m0_done", m0_hready, 1'b1);
        chk32("t1_m0_rdata", m0_hrdata, 32'hDEAD_BEEF);
        chk32("t1_bus_idle", 32'(biu_htrans), 32'd0);
        tick();

        // Simultaneous requests after reset: m0 first, m1 back-to-back
        do_reset();
        m0_htrans = 2'b10; m0_haddr = 32'h0000_1000; m0_hwrite = 1'b0;
        m1_htrans = 2'b10; m1_haddr = 32'h0000_2000; m1_hwrite = 1'b1; m1_hwdata = 32'h1111_2222;
        settle();
        tick(); idle_masters(); settle();
        chk32("t2_first_addr", biu_haddr, 32'h0000_1000);
        chk1("t2_m1_stall", m1_hready, 1'b0);
        tick(); settle();
        chk32("t2_second_addr", biu_haddr, 32'h0000_2000);
        chk32("t2_second_ns", 32'(biu_htrans), 32'd2);
        chk1("t2_m0_done", m0_hready, 1'b1);
        chk1("t2_m1_wait", m1_hready, 1'b0);
        tick(); settle();
        chk1("t2_m1_done", m1_hready, 1'b1);
        chk32("t2_hwdata", biu_hwdata, 32'h1111_2222);
        chk32("t2_idle", 32'(biu_htrans), 32'd0);
        tick();

        // m1 write with three slave wait states, m0 address parked on the bus
        m1_htrans = 2'b10; m1_haddr = 32'h0000_3000; m1_hwrite = 1'b1; m1_hwdata = 32'h5A5A_5A5A; settle();
        tick(); m1_htrans = 2'b00; m0_htrans = 2'b10; m0_haddr = 32'h0000_4000; m0_hwrite = 1'b0; settle();
        chk32("t3_m1_addr", biu_haddr, 32'h0000_3000);
        tick(); m0_htrans = 2'b00; pad_hready = 1'b0; settle();
        for (int k = 0; k < 3; k++) begin
            chk1("t3_m1_wait", m1_hready, 1'b0);
            chk32("t3_hwdata", biu_hwdata, 32'h5A5A_5A5A);
            chk32("t3_m0_addr_held", biu_haddr, 32'h0000_4000);
            chk32("t3_m0_ns_held", 32'(biu_htrans), 32'd2);
            tick();
            if (k == 2) pad_hready = 1'b1;
            settle();
        end
        chk1("t3_m1_done", m1_hready, 1'b1);
        chk32("t3_hwdata_last", biu_hwdata, 32'h5A5A_5A5A);
        chk32("t3_m0_addr_acc", biu_haddr, 32'h0000_4000);
        tick(); settle();
        chk1("t3_m0_done", m0_hready, 1'b1);
        chk32("t3_idle", 32'(biu_htrans), 32'd0);
        tick();

        // Two-cycle ERROR on m0 read, m1 pipelined write unaffected
        m0_htrans = 2'b10; m0_haddr = 32'h0000_5000; m0_hwrite = 1'b0; settle();
        tick(); m0_htrans = 2'b00; m1_htrans = 2'b10; m1_haddr = 32'h0000_6000; m1_hwrite = 1'b1;
        m1_hwdata = 32'h0BAD_F00D; settle();
        chk32("t4_m0_addr", biu_haddr, 32'h0000_5000);
        tick(); m1_htrans = 2'b00; pad_hready = 1'b0; pad_hresp = 2'b01; settle();
        chk1("t4_err1_resp", m0_hresp, 1'b1);
        chk1("t4_err1_rdy", m0_hready, 1'b0);
        chk1("t4_err1_m1_resp", m1_hresp, 1'b0);
        chk32("t4_m1_addr", biu_haddr, 32'h0000_6000);
        tick(); pad_hready = 1'b1; settle();
        chk1("t4_err2_resp", m0_hresp, 1'b1);
        chk1("t4_err2_rdy", m0_hready, 1'b1);
        chk1("t4_err2_m1_resp", m1_hresp, 1'b0);
        chk32("t4_m1_ns", 32'(biu_htrans), 32'd2);
        tick(); pad_hresp = 2'b00; settle();
        chk1("t4_m1_done", m1_hready, 1'b1);
        chk1("t4_m1_ok", m1_hresp, 1'b0);
        chk1("t4_m0_resp_clr", m0_hresp, 1'b0);
        chk32("t4_m1_hwdata", biu_hwdata, 32'h0BAD_F00D);
        tick();

        // Reset while both masters are pending and outstanding
        m0_htrans = 2'b10; m0_haddr = 32'h0000_9000; m1_htrans = 2'b10; m1_haddr = 32'h0000_A000; settle();
        tick(); idle_masters(); pad_hready = 1'b0; settle();
        chk32("t5_pre_ns", 32'(biu_htrans), 32'd2);
        chk1("t5_pre_m0_stall", m0_hready, 1'b0);
        #1 rst_b = 1'b0;
        #1;
        chk32("t5_rst_idle", 32'(biu_htrans), 32'd0);
        chk1("t5_rst_m0_rdy", m0_hready, 1'b1);
        chk1("t5_rst_m1_rdy", m1_hready, 1'b1);
        tick();
        tick();
        rst_b = 1'b1; pad_hready = 1'b1; settle();
        for (int k = 0; k < 4; k++) begin
            chk32("t5_no_stray", 32'(biu_htrans), 32'd0);
            tick(); settle();
        end

`ifdef AHB_ARB_LOCK_EN
        // m1 locked sequence keeps m0 off the bus until the unlocked beat
        for (int k = 0; k < 4; k++) begin
            m1_htrans = 2'b10; m1_haddr = 32'h0000_7000 + 4 * k; m1_hwrite = 1'b1;
            m1_hlock = (k < 3); m1_hwdata = 32'(k); settle();
            if (k > 0) begin
                chk1("t6_m1_beat_done", m1_hready, 1'b1);
                chk32("t6_m0_blocked", 32'(biu_htrans), 32'd0);
            end
            tick(); m1_htrans = 2'b00; m0_htrans = (k == 0) ? 2'b10 : 2'b00; m0_haddr = 32'h0000_8000; settle();
            chk32("t6_m1_addr", biu_haddr, 32'h0000_7000 + 4 * k);
            chk32("t6_m1_ns", 32'(biu_htrans), 32'd2);
            chk1("t6_hlock", biu_hlock, (k < 3));
            tick();
        end
        m1_hlock = 1'b0; settle();
        chk1("t6_m1_last_done", m1_hready, 1'b1);
        chk32("t6_m0_granted", biu_haddr, 32'h0000_8000);
        chk32("t6_m0_ns", 32'(biu_htrans), 32'd2);
        chk1("t6_hlock_off", biu_hlock, 1'b0);
        tick(); settle();
        chk1("t6_m0_done", m0_hready, 1'b1);
`else
        // hlock ignored: m0 follows m1 immediately even though m1 asked for a lock
        m1_htrans = 2'b10; m1_haddr = 32'h0000_B000; m1_hwrite = 1'b1; m1_hlock = 1'b1; settle();
        tick(); m1_htrans = 2'b00; m0_htrans = 2'b10; m0_haddr = 32'h0000_C000; m0_hwrite = 1'b0; settle();
        chk32("t6_m1_addr", biu_haddr, 32'h0000_B000);
        chk1("t6_hlock_tied", biu_hlock, 1'b0);
        tick(); m0_htrans = 2'b00; m1_hlock = 1'b0; settle();
        chk32("t6_m0_granted", biu_haddr, 32'h0000_C000);
        chk32("t6_m0_ns", 32'(biu_htrans), 32'd2);
        tick(); settle();
        chk1("t6_m0_done", m0_hready, 1'b1);
`endif
        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
